// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: accepts one cipher key, then emits round keys
// 0..10 over a valid/ready channel, computing each next key from the current one.
module aes_key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_index,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    // Forward S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    logic [0:0]   state;
    logic [127:0] cur_key;
    logic [3:0]   round;
    logic [7:0]   rcon;
    logic [127:0] next_key;

    // Next round key: one column step of the Nk=4 expansion, all four words at once.
    always_comb begin
        logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;
        w0   = cur_key[127:96];
        w1   = cur_key[95:64];
        w2   = cur_key[63:32];
        w3   = cur_key[31:0];
        temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
               ^ {rcon, 24'h0};
        n0   = w0 ^ temp;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_key <= '0;
            round   <= '0;
            rcon    <= 8'h01;
        end else begin
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        cur_key <= key_in;
                        round   <= '0;
                        rcon    <= 8'h01;
                        state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (round == LAST_ROUND) begin
                            state <= IDLE;
                        end else begin
                            cur_key <= next_key;
                            round   <= round + 4'd1;
                            rcon    <= xtime(rcon);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    assign key_ready = (state == IDLE);
    assign rk_valid  = (state == EMIT);
    assign busy      = (state == EMIT);
    assign rk_out    = cur_key;
    assign rk_index  = round;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: an algebraic FIPS-197 key schedule model
// compared every cycle, plus directed vectors with hand-computed round keys.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_index;
    logic         rk_valid;
    logic         rk_ready = 1'b1;
    logic         busy;

    aes_key_expand dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_out    (rk_out),
        .rk_index  (rk_index),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (GF(2^8) arithmetic, word expansion) ----------------
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1B) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gf_mul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    end

    // Model of the transfer protocol: which round key should be on offer, if any.
    logic [127:0] m_keys [11];
    logic         m_active = 1'b0;
    int           m_idx = 0;
    int           cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_idx    = 0;
        end else if (!m_active) begin
            if (key_valid) begin
                for (int r = 0; r < 11; r++) m_keys[r] = round_key(key_in, r);
                m_active = 1'b1;
                m_idx    = 0;
            end
        end else if (rk_ready) begin
            if (m_idx == 10) m_active = 1'b0;
            else m_idx++;
        end
    end

    always @(posedge clk) cyc++;

    // Per-cycle compare plus transfer capture, sampled mid-cycle.
    logic [127:0] cap [11];
    int           valid_cnt = 0;
    bit           done = 1'b0;
    int           t_acc = -1;
    int           t_last = -1;

    always @(negedge clk) begin
        if (rst_n) begin
            check("key_ready", key_ready, !m_active);
            check("rk_valid", rk_valid, m_active);
            check("busy", busy, m_active);
            if (m_active) begin
                check("rk_index", rk_index, m_idx);
                check("rk_out", rk_out, m_keys[m_idx]);
            end
            if (rk_valid) valid_cnt++;
            if (rk_valid && rk_ready && rk_index <= 4'd10) begin
                cap[rk_index] = rk_out;
                if (rk_index == 4'd10) begin
                    done   = 1'b1;
                    t_last = cyc;
                end
            end
            if (key_valid && key_ready) t_acc = cyc;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_key(input logic [127:0] k);
        bit ok = 1'b0;
        @(posedge clk); #1;
        key_in    = k;
        key_valid = 1'b1;
        done      = 1'b0;
        valid_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (key_ready) begin ok = 1'b1; break; end
        end
        check("key_accept", ok, 1'b1);
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (done) break;
        end
        check(name, done, 1'b1);
    endtask

    task automatic wait_index(input logic [3:0] idx);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (rk_valid && rk_index == idx) begin ok = 1'b1; break; end
        end
        check("reach_index", ok, 1'b1);
    endtask

    localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_SEQ = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B   = 128'hffeeddccbbaa99887766554433221100;

    initial begin
        logic [127:0] held;

        #3;
        check("reset_key_ready", key_ready, 1'b1);
        check("reset_rk_valid", rk_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_rk_out", rk_out, 128'h0);
        check("reset_rk_index", rk_index, 4'd0);
        #10;
        check("model_sbox_00", sbox_m[8'h00], 8'h63);
        check("model_sbox_53", sbox_m[8'h53], 8'hed);
        check("model_a1_r1", round_key(KEY_A1, 1), 128'ha0fafe1788542cb123a339392a6c7605);
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS-197 A.1 with no stall
        send_key(KEY_A1);
        wait_done("a1_done");
        check("a1_round0", cap[0], KEY_A1);
        check("a1_round1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("a1_round10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("a1_valid_cycles", valid_cnt, 11);

        // All-zero key
        send_key(128'h0);
        wait_done("zero_done");
        check("zero_round1", cap[1], 128'h62636363626363636263636362636363);
        check("zero_round10", cap[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Backpressure for three cycles at round 4
        send_key(KEY_SEQ);
        wait_index(4'd4);
        rk_ready = 1'b0;
        held = rk_out;
        repeat (3) begin
            @(posedge clk); #1;
            check("stall_rk_out", rk_out, held);
            check("stall_rk_index", rk_index, 4'd4);
            check("stall_rk_valid", rk_valid, 1'b1);
        end
        rk_ready = 1'b1;
        wait_done("stall_done");
        check("stall_round10", cap[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("stall_valid_cycles", valid_cnt, 14);

        // Second key offered while busy: ignored until one cycle after round 10
        send_key(KEY_SEQ);
        @(posedge clk); #1;
        key_in    = KEY_B;
        key_valid = 1'b1;
        check("busy_key_ready", key_ready, 1'b0);
        wait_done("busy_first_done");
        check("busy_first_round0", cap[0], KEY_SEQ);
        check("busy_first_round10", cap[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (t_acc > t_last) break;
        end
        key_valid = 1'b0;
        check("busy_accept_cycle", t_acc, t_last + 1);
        wait_done("busy_second_done");
        check("busy_second_round0", cap[0], KEY_B);

        // Asynchronous reset in the middle of a schedule
        send_key(KEY_A1);
        wait_index(4'd6);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rk_valid", rk_valid, 1'b0);
        check("midrst_key_ready", key_ready, 1'b1);
        check("midrst_rk_out", rk_out, 128'h0);
        check("midrst_rk_index", rk_index, 4'd0);
        check("midrst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_key(KEY_SEQ);
        wait_done("midrst_done");
        check("midrst_round0", cap[0], KEY_SEQ);
        check("midrst_round10", cap[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("midrst_valid_cycles", valid_cnt, 11);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d vectors expected completion", vectors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES-128 key schedule generator feeding the AddRoundKey stage of the encryption datapath. It accepts one 128-bit cipher key through a valid/ready handshake. It then emits the 11 round keys (round 0 through round 10) in order, one per accepted output transfer, as defined by FIPS-197 §5.2. The output channel is backpressure-capable, so the round controller pulls keys at its own pace.

## Interface
- No parameters (AES-128 only; Nk=4, Nr=10 fixed).
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- key_in  in  128  cipher key; bits [127:120] are key byte 0.
- key_valid  in  1  key_in is valid.
- key_ready  out  1  block can accept a key (high only in IDLE).
- rk_out  out  128  current round key, same byte ordering as key_in.
- rk_index  out  4  round number of rk_out, 0..10.
- rk_valid  out  1  rk_out/rk_index are valid.
- rk_ready  in  1  consumer accepts rk_out this cycle.
- busy  out  1  high while a schedule is in progress (EMIT state).

## Operation
- The FSM has two states: IDLE and EMIT. Reset state is IDLE.
- In IDLE: key_ready=1, rk_valid=0, busy=0.
  - A key is accepted on the edge where key_valid && key_ready.
  - On that edge: cur_key <= key_in, round <= 0, rcon <= 8'h01, state <= EMIT.
- In EMIT: key_ready=0, busy=1, rk_valid=1, rk_out=cur_key, rk_index=round.
- Output transfer occurs on the edge where rk_valid && rk_ready.
  - If round < 10: cur_key <= next_key, round <= round+1, rcon <= xtime(rcon).
  - If round == 10: state <= IDLE.
- next_key is combinational from cur_key and rcon.
  - Words: w0=cur_key[127:96], w1=[95:64], w2=[63:32], w3=[31:0].
  - temp = SubWord(RotWord(w3)) ^ {rcon,24'h0}, where RotWord({a,b,c,d}) = {b,c,d,a}.
  - n0=w0^temp, n1=w1^n0, n2=w2^n1, n3=w3^n2; next_key={n0,n1,n2,n3}.
- SubWord uses four instances of the FIPS-197 forward S-box, implemented as a combinational 256-entry byte lookup inside this block.
- The rcon sequence is 01,02,04,08,10,20,40,80,1B,36.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
- Round 0 key equals key_in exactly.
- key_in and key_valid are ignored while in EMIT; a new key is never captured mid-schedule.
- rk_out, rk_index and rk_valid are held stable while rk_valid && !rk_ready. This is standard valid/ready: valid never drops without a transfer.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE, cur_key=0, round=0, rcon=8'h01.
  - Outputs: key_ready=1, rk_valid=0, busy=0, rk_out=0, rk_index=0.
- Reset asserted mid-schedule aborts it immediately. Outputs take reset values without waiting for a clock edge, and the partial schedule is discarded.
- Latency:
  - Key accepted at edge T: round 0 is valid from T+1.
  - With rk_ready held high, round k transfers at edge T+1+k.
  - The round 10 transfer occurs at edge T+11.
  - key_ready=1 again from T+11, so the next key can be accepted at edge T+12.
- Throughput: 11 round keys per 12 cycles for back-to-back keys with no output stall.
- Simultaneous events:
  - key_valid asserted in the same cycle as the final (round 10) transfer is not accepted, because key_ready=0 in that cycle.
  - The round 10 transfer is the only transition from EMIT to IDLE.
- All outputs are driven from registers or from registered state decoded without combinational paths from inputs. There is no input-to-output combinational path.

## Test plan
- FIPS-197 A.1: key_in=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1.
  - Expect round 0 = key.
  - Expect round 1 = a0fafe1788542cb123a339392a6c7605.
  - Expect round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at rk_index=10, exactly 11 consecutive rk_valid cycles.
- Zero key:
  - Expect round 1 = 62636363626363636263636362636363.
  - Expect round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: key 000102030405060708090a0b0c0d0e0f, rk_ready=0 for 3 cycles when rk_index=4.
  - rk_out/rk_index stay stable and rk_valid stays high during the stall.
  - Round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Key during busy: drive key_valid=1 with a different key while busy=1.
  - key_ready stays 0 and the schedule matches the original key.
  - The second key is accepted one cycle after the round 10 transfer.
- Reset mid-schedule: assert rst_n=0 at rk_index=6.
  - Outputs go to reset values asynchronously: rk_valid=0, key_ready=1, rk_out=0.
  - A new key afterwards produces a correct full schedule starting at index 0.
